// File: rtl/hpm_counter_bank.sv
// Performance-monitor counter bank: N event-selectable counters with threshold compare,
// sticky overflow and inhibit, accessed through a small CSR-style register window.
module hpm_counter_bank #(
    parameter int unsigned NumCounters = 6,
    parameter int unsigned CntWidth    = 64,
    parameter int unsigned NumEvents   = 32,
    parameter int unsigned IncWidth    = 2,
    parameter int unsigned XLEN        = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          debug_mode_i,
    input  logic [7:0]                    addr_i,
    input  logic                          we_i,
    input  logic [XLEN-1:0]               wdata_i,
    output logic [XLEN-1:0]               rdata_o,
    output logic                          err_o,
    input  logic [NumEvents*IncWidth-1:0] event_inc_i,
    output logic                          irq_o
);

    localparam int unsigned SelW = (NumEvents > 1) ? $clog2(NumEvents) : 1;
    // Bits of a counter/threshold reachable through the lo half; the rest belong to hi.
    localparam logic [CntWidth-1:0] LoMask = CntWidth'((65'd1 << XLEN) - 65'd1);

    typedef enum logic [2:0] {
        KindCntLo  = 3'd0,
        KindCntHi  = 3'd1,
        KindEvtSel = 3'd2,
        KindThrLo  = 3'd3,
        KindThrHi  = 3'd4,
        KindOvf    = 3'd5,
        KindInh    = 3'd6,
        KindBad    = 3'd7
    } kind_e;

    kind_e               kind;
    logic [4:0]          idx;
    logic                idx_ok;
    logic                legal;
    logic                wr;
    logic [CntWidth-1:0] lo_val;
    logic [CntWidth-1:0] hi_val;

    logic [CntWidth-1:0]    cnt_q   [NumCounters];
    logic [CntWidth-1:0]    cnt_d   [NumCounters];
    logic [CntWidth-1:0]    thr_q   [NumCounters];
    logic [CntWidth-1:0]    thr_d   [NumCounters];
    logic [SelW-1:0]        sel_q   [NumCounters];
    logic [SelW-1:0]        sel_d   [NumCounters];
    logic [NumCounters-1:0] ovf_q;
    logic [NumCounters-1:0] ovf_d;
    logic [NumCounters-1:0] inh_q;
    logic [NumCounters-1:0] inh_d;
    logic [NumCounters-1:0] hit;
    logic [NumCounters-1:0] cnt_wr;
    logic [NumCounters-1:0] cnt_en;

    logic [IncWidth-1:0] inc_arr [NumEvents];
    logic [IncWidth-1:0] sel_inc [NumCounters];
    logic [CntWidth:0]   sum     [NumCounters];

    always_comb begin
        kind   = kind_e'(addr_i[7:5]);
        idx    = addr_i[4:0];
        idx_ok = 32'(idx) < NumCounters;
        legal  = 1'b0;
        case (kind)
            KindCntLo, KindEvtSel, KindThrLo: legal = idx_ok;
            KindCntHi, KindThrHi:             legal = idx_ok && (XLEN == 32);
            KindOvf, KindInh:                 legal = 1'b1;
            default:                          legal = 1'b0;
        endcase
        wr     = we_i && legal;
        lo_val = CntWidth'(64'(wdata_i));
        hi_val = CntWidth'(64'(wdata_i) << 32);
    end

    always_comb begin
        for (int e = 0; e < NumEvents; e++) begin
            inc_arr[e] = event_inc_i[e*IncWidth +: IncWidth];
        end
    end

    // Selector 0 and any selector beyond the implemented events contribute nothing.
    always_comb begin
        for (int i = 0; i < NumCounters; i++) begin
            sel_inc[i] = '0;
            if (sel_q[i] != '0 && 32'(sel_q[i]) < NumEvents) begin
                sel_inc[i] = inc_arr[sel_q[i]];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NumCounters; i++) begin
            cnt_wr[i] = wr && (idx == 5'(i)) &&
                        (kind == KindCntLo || kind == KindCntHi || kind == KindEvtSel);
            cnt_en[i] = !debug_mode_i && !inh_q[i] && !cnt_wr[i];
        end
    end

    always_comb begin
        inh_d = inh_q;
        if (wr && kind == KindInh) begin
            inh_d = wdata_i[NumCounters-1:0];
        end
        for (int i = 0; i < NumCounters; i++) begin
            cnt_d[i] = cnt_q[i];
            thr_d[i] = thr_q[i];
            sel_d[i] = sel_q[i];
            ovf_d[i] = ovf_q[i];
            sum[i]   = {1'b0, cnt_q[i]} + (CntWidth+1)'(sel_inc[i]);

            if (cnt_en[i]) begin
                cnt_d[i] = sum[i][CntWidth-1:0];
            end

            if (wr && idx == 5'(i)) begin
                case (kind)
                    KindCntLo:  cnt_d[i] = (cnt_q[i] & ~LoMask) | (lo_val & LoMask);
                    KindCntHi:  cnt_d[i] = (cnt_q[i] & LoMask) | (hi_val & ~LoMask);
                    KindEvtSel: begin
                        sel_d[i] = wdata_i[SelW-1:0];
                        cnt_d[i] = '0;
                        ovf_d[i] = 1'b0;
                    end
                    KindThrLo:  thr_d[i] = (thr_q[i] & ~LoMask) | (lo_val & LoMask);
                    KindThrHi:  thr_d[i] = (thr_q[i] & LoMask) | (hi_val & ~LoMask);
                    default:    ;
                endcase
            end

            // Clear first so a carry in the same cycle keeps the flag set.
            if (wr && kind == KindOvf && wdata_i[i]) begin
                ovf_d[i] = 1'b0;
            end
            if (cnt_en[i] && sum[i][CntWidth]) begin
                ovf_d[i] = 1'b1;
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        err_o   = !legal;
        if (legal) begin
            case (kind)
                KindCntLo:  rdata_o = XLEN'(cnt_q[idx]);
                KindCntHi:  rdata_o = XLEN'(cnt_q[idx] >> 32);
                KindEvtSel: rdata_o = XLEN'(sel_q[idx]);
                KindThrLo:  rdata_o = XLEN'(thr_q[idx]);
                KindThrHi:  rdata_o = XLEN'(thr_q[idx] >> 32);
                KindOvf:    rdata_o = XLEN'(ovf_q);
                KindInh:    rdata_o = XLEN'(inh_q);
                default:    rdata_o = '0;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < NumCounters; i++) begin
            hit[i] = (thr_q[i] != '0) && (cnt_q[i] >= thr_q[i]);
        end
        irq_o = |((ovf_q | hit) & ~inh_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumCounters; i++) begin
                cnt_q[i] <= '0;
                thr_q[i] <= '0;
                sel_q[i] <= '0;
            end
            ovf_q <= '0;
            inh_q <= '0;
        end else begin
            for (int i = 0; i < NumCounters; i++) begin
                cnt_q[i] <= cnt_d[i];
                thr_q[i] <= thr_d[i];
                sel_q[i] <= sel_d[i];
            end
            ovf_q <= ovf_d;
            inh_q <= inh_d;
        end
    end

endmodule

// File: tb/tb_hpm_counter_bank.sv
// Self-checking bench for hpm_counter_bank: register vector table, directed corner
// sequences, an XLEN=32 instance, and random traffic against a behavioural model.
module tb_hpm_counter_bank;

   logic        clk;
   logic        rst_n;
   logic        debug;
   logic [7:0]  addr;
   logic        we;
   logic [63:0] wdata;
   logic [63:0] einc;
   logic [63:0] rdata;
   logic        err;
   logic        irq;

   logic [7:0]  addr32;
   logic        we32;
   logic [31:0] wdata32;
   logic [63:0] einc32;
   logic [31:0] rdata32;
   logic        err32;
   logic        irq32;

   int checks;
   int errors;

   // Behavioural model state for the 64-bit instance (6 counters, 64-bit width)
   longint unsigned mcnt [6];
   longint unsigned mthr [6];
   int              msel [6];
   bit [5:0]        movf;
   bit [5:0]        minh;

   typedef struct {
      logic [7:0]  addr;
      logic        we;
      logic [63:0] wdata;
      logic [63:0] expRdata;
      logic        expErr;
   } vec_t;

   vec_t tbl [17];

   hpm_counter_bank #(
      .NumCounters(6), .CntWidth(64), .NumEvents(32), .IncWidth(2), .XLEN(64)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .debug_mode_i(debug), .addr_i(addr), .we_i(we),
      .wdata_i(wdata), .rdata_o(rdata), .err_o(err), .event_inc_i(einc), .irq_o(irq)
   );

   hpm_counter_bank #(
      .NumCounters(6), .CntWidth(64), .NumEvents(32), .IncWidth(2), .XLEN(32)
   ) dut32 (
      .clk_i(clk), .rst_ni(rst_n), .debug_mode_i(debug), .addr_i(addr32), .we_i(we32),
      .wdata_i(wdata32), .rdata_o(rdata32), .err_o(err32), .event_inc_i(einc32), .irq_o(irq32)
   );

   // Free-running clock, 10 time units per period
   always #5 clk = ~clk;

   // Compare one value and log any disagreement
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic checkDut(input string name, input logic [63:0] expR, input logic expE, input logic expI);
      checkOutput({name, ".rdata"}, rdata, expR);
      checkOutput({name, ".err"}, 64'(err), 64'(expE));
      checkOutput({name, ".irq"}, 64'(irq), 64'(expI));
   endtask

   // Drive the 64-bit instance inputs (called at a falling edge) and let them settle
   task automatic applyStimulus(input logic [7:0] a, input logic w, input logic [63:0] d,
                                input logic g, input logic [63:0] inc);
      addr  = a;
      we    = w;
      wdata = d;
      debug = g;
      einc  = inc;
      #1;
   endtask

   task automatic drive32(input logic [7:0] a, input logic w, input logic [31:0] d, input logic [63:0] inc);
      addr32  = a;
      we32    = w;
      wdata32 = d;
      einc32  = inc;
   endtask

   function automatic bit modelLegal(input logic [7:0] a);
      int k;
      int ix;
      k  = int'(a[7:5]);
      ix = int'(a[4:0]);
      if (k == 0 || k == 2 || k == 3) return ix < 6;
      if (k == 5 || k == 6) return 1'b1;
      return 1'b0;
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 6; i++) begin
         mcnt[i] = 0;
         mthr[i] = 0;
         msel[i] = 0;
      end
      movf = '0;
      minh = '0;
   endtask

   task automatic modelRead(input logic [7:0] a, output logic [63:0] rd, output logic er);
      int k;
      int ix;
      k  = int'(a[7:5]);
      ix = int'(a[4:0]);
      rd = 64'h0;
      er = !modelLegal(a);
      if (!er) begin
         case (k)
            0: rd = mcnt[ix];
            2: rd = 64'(msel[ix]);
            3: rd = mthr[ix];
            5: rd = 64'(movf);
            6: rd = 64'(minh);
            default: rd = 64'h0;
         endcase
      end
   endtask

   function automatic logic modelIrq();
      for (int i = 0; i < 6; i++) begin
         if (!minh[i] && (movf[i] || (mthr[i] != 0 && mcnt[i] >= mthr[i]))) return 1'b1;
      end
      return 1'b0;
   endfunction

   // One clock of the model: increments from the selected events, then register writes
   task automatic modelStep();
      int              k;
      int              ix;
      bit              wrOk;
      bit [5:0]        clr;
      bit [5:0]        setov;
      longint unsigned ncnt [6];
      longint unsigned incv;
      longint unsigned nv;
      k     = int'(addr[7:5]);
      ix    = int'(addr[4:0]);
      wrOk  = we && modelLegal(addr);
      clr   = '0;
      setov = '0;
      for (int i = 0; i < 6; i++) begin
         ncnt[i] = mcnt[i];
         if (!debug && !minh[i] && !(wrOk && ix == i && k <= 2)) begin
            incv = (msel[i] != 0) ? ((einc >> (2 * msel[i])) & 64'd3) : 64'd0;
            nv   = mcnt[i] + incv;
            if (nv < mcnt[i]) setov[i] = 1'b1;
            ncnt[i] = nv;
         end
      end
      if (wrOk) begin
         case (k)
            0: ncnt[ix] = wdata;
            2: begin
               msel[ix] = int'(wdata & 64'd31);
               ncnt[ix] = 0;
               clr[ix]  = 1'b1;
            end
            3: mthr[ix] = wdata;
            5: clr = clr | wdata[5:0];
            6: minh = wdata[5:0];
            default: ;
         endcase
      end
      for (int i = 0; i < 6; i++) mcnt[i] = ncnt[i];
      movf = (movf & ~clr) | setov;
   endtask

   task automatic tick();
      @(posedge clk);
      modelStep();
      @(negedge clk);
   endtask

   // Main test sequence
   initial begin
      logic [63:0] er;
      logic        ee;
      logic        ei;
      logic [7:0]  ra;
      logic [63:0] rd;
      int          rk;

      checks = 0;
      errors = 0;
      clk    = 1'b0;
      rst_n  = 1'b0;
      addr = '0; we = 1'b0; wdata = '0; debug = 1'b0; einc = '0;
      drive32(8'h00, 1'b0, 32'h0, 64'h0);
      modelReset();

      tbl[0]  = '{8'h00, 1'b0, 64'h0,    64'h0,    1'b0};
      tbl[1]  = '{8'h40, 1'b1, 64'hFF,   64'h0,    1'b0};
      tbl[2]  = '{8'h40, 1'b0, 64'h0,    64'h1F,   1'b0};
      tbl[3]  = '{8'hE0, 1'b0, 64'h0,    64'h0,    1'b1};
      tbl[4]  = '{8'h07, 1'b1, 64'h55,   64'h0,    1'b1};
      tbl[5]  = '{8'h20, 1'b0, 64'h0,    64'h0,    1'b1};
      tbl[6]  = '{8'h03, 1'b1, 64'h1234, 64'h0,    1'b0};
      tbl[7]  = '{8'h03, 1'b0, 64'h0,    64'h1234, 1'b0};
      tbl[8]  = '{8'h63, 1'b1, 64'h2000, 64'h0,    1'b0};
      tbl[9]  = '{8'h63, 1'b0, 64'h0,    64'h2000, 1'b0};
      tbl[10] = '{8'hC0, 1'b1, 64'h3F,   64'h0,    1'b0};
      tbl[11] = '{8'hC0, 1'b0, 64'h0,    64'h3F,   1'b0};
      tbl[12] = '{8'hC0, 1'b1, 64'h0,    64'h3F,   1'b0};
      tbl[13] = '{8'hA0, 1'b0, 64'h0,    64'h0,    1'b0};
      tbl[14] = '{8'h86, 1'b0, 64'h0,    64'h0,    1'b1};
      tbl[15] = '{8'h07, 1'b0, 64'h0,    64'h0,    1'b1};
      tbl[16] = '{8'h00, 1'b0, 64'h0,    64'h0,    1'b0};

      @(negedge clk);
      #1;
      checkDut("in_reset", 64'h0, 1'b0, 1'b0);
      checkOutput("in_reset32.rdata", 64'(rdata32), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(8'h00, 1'b0, 64'h0, 1'b0, 64'h0);
      checkDut("post_reset", 64'h0, 1'b0, 1'b0);
      tick();

      $display("[TB] register vector table");
      for (int i = 0; i < 17; i++) begin
         applyStimulus(tbl[i].addr, tbl[i].we, tbl[i].wdata, 1'b0, 64'h0);
         checkDut($sformatf("vec%0d", i), tbl[i].expRdata, tbl[i].expErr, 1'b0);
         tick();
      end

      $display("[TB] count and debug freeze");
      applyStimulus(8'h40, 1'b1, 64'd5, 1'b0, 64'h0); tick();
      repeat (4) begin applyStimulus(8'h00, 1'b0, 64'h0, 1'b0, 64'd3 << 10); tick(); end
      applyStimulus(8'h00, 1'b0, 64'h0, 1'b0, 64'h0);
      checkDut("count", 64'd12, 1'b0, 1'b0);
      repeat (2) begin applyStimulus(8'h00, 1'b0, 64'h0, 1'b1, 64'd3 << 10); tick(); end
      applyStimulus(8'h00, 1'b0, 64'h0, 1'b0, 64'h0);
      checkDut("debug_freeze", 64'd12, 1'b0, 1'b0);

      $display("[TB] wrap and overflow");
      applyStimulus(8'h00, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 64'h0); tick();
      applyStimulus(8'h00, 1'b0, 64'h0, 1'b0, 64'd3 << 10);
      checkDut("wrap_pre", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
      tick();
      applyStimulus(8'h00, 1'b0, 64'h0, 1'b0, 64'h0);
      checkDut("wrap_cnt", 64'd1, 1'b0, 1'b1);
      applyStimulus(8'hA0, 1'b0, 64'h0, 1'b0, 64'h0);
      checkDut("wrap_status", 64'd1, 1'b0, 1'b1);
      applyStimulus(8'hA0, 1'b1, 64'd1, 1'b0, 64'h0); tick();
      applyStimulus(8'hA0, 1'b0, 64'h0, 1'b0, 64'h0);
      checkDut("status_w1c", 64'h0, 1'b0, 1'b0);

      $display("[TB] threshold and inhibit");
      applyStimulus(8'h61, 1'b1, 64'd10, 1'b0, 64'h0); tick();
      applyStimulus(8'h41, 1'b1, 64'd5, 1'b0, 64'h0); tick();
      for (int k = 0; k < 12; k++) begin
         applyStimulus(8'h01, 1'b0, 64'h0, 1'b0, 64'd1 << 10);
         checkDut($sformatf("thr_ramp%0d", k), 64'(k), 1'b0, k >= 10);
         tick();
      end
      applyStimulus(8'hC0, 1'b1, 64'd2, 1'b0, 64'd1 << 10);
      checkDut("inh_write", 64'h0, 1'b0, 1'b1);
      tick();
      repeat (2) begin
         applyStimulus(8'h01, 1'b0, 64'h0, 1'b0, 64'd1 << 10);
         checkDut("inh_frozen", 64'd13, 1'b0, 1'b0);
         tick();
      end

      $display("[TB] write priority over increment");
      applyStimulus(8'h42, 1'b1, 64'd6, 1'b0, 64'h0); tick();
      applyStimulus(8'h43, 1'b1, 64'd6, 1'b0, 64'h0); tick();
      applyStimulus(8'h02, 1'b1, 64'd100, 1'b0, 64'd2 << 12); tick();
      applyStimulus(8'h02, 1'b0, 64'h0, 1'b0, 64'h0);
      checkDut("wr_priority", 64'd100, 1'b0, 1'b0);
      applyStimulus(8'h03, 1'b0, 64'h0, 1'b0, 64'h0);
      checkDut("wr_neighbour", 64'd2, 1'b0, 1'b0);

      $display("[TB] illegal accesses");
      applyStimulus(8'h07, 1'b1, 64'hDEAD, 1'b0, 64'h0);
      checkDut("illegal_idx", 64'h0, 1'b1, 1'b0);
      tick();
      applyStimulus(8'hE3, 1'b1, 64'hDEAD, 1'b0, 64'h0);
      checkDut("illegal_kind", 64'h0, 1'b1, 1'b0);
      tick();
      applyStimulus(8'h23, 1'b1, 64'h5, 1'b0, 64'h0);
      checkDut("hi_at_xlen64", 64'h0, 1'b1, 1'b0);
      tick();
      applyStimulus(8'h03, 1'b0, 64'h0, 1'b0, 64'h0);
      checkDut("no_change", 64'd2, 1'b0, 1'b0);

      $display("[TB] XLEN=32 hi/lo carry");
      drive32(8'h40, 1'b1, 32'd1, 64'h0);
      applyStimulus(8'h00, 1'b0, 64'h0, 1'b0, 64'h0); tick();
      drive32(8'h20, 1'b1, 32'd1, 64'h0);
      applyStimulus(8'h00, 1'b0, 64'h0, 1'b0, 64'h0); tick();
      drive32(8'h00, 1'b1, 32'hFFFF_FFFF, 64'h0);
      applyStimulus(8'h00, 1'b0, 64'h0, 1'b0, 64'h0); tick();
      drive32(8'h00, 1'b0, 32'h0, 64'h4);
      applyStimulus(8'h00, 1'b0, 64'h0, 1'b0, 64'h0);
      checkOutput("x32_lo_pre", 64'(rdata32), 64'hFFFF_FFFF);
      tick();
      drive32(8'h00, 1'b0, 32'h0, 64'h0);
      applyStimulus(8'h00, 1'b0, 64'h0, 1'b0, 64'h0);
      checkOutput("x32_lo", 64'(rdata32), 64'h0);
      drive32(8'h20, 1'b0, 32'h0, 64'h0);
      applyStimulus(8'h00, 1'b0, 64'h0, 1'b0, 64'h0);
      checkOutput("x32_hi", 64'(rdata32), 64'd2);
      checkOutput("x32_hi.err", 64'(err32), 64'h0);
      drive32(8'hA0, 1'b0, 32'h0, 64'h0);
      applyStimulus(8'h00, 1'b0, 64'h0, 1'b0, 64'h0);
      checkOutput("x32_status", 64'(rdata32), 64'h0);
      checkOutput("x32_irq", 64'(irq32), 64'h0);
      drive32(8'h00, 1'b0, 32'h0, 64'h0);

      $display("[TB] asynchronous reset mid-count");
      applyStimulus(8'h00, 1'b0, 64'h0, 1'b0, 64'd3 << 10); tick(); tick();
      #2;
      rst_n = 1'b0;
      #1;
      checkDut("async_rst", 64'h0, 1'b0, 1'b0);
      modelReset();
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(8'h03, 1'b0, 64'h0, 1'b0, 64'h0);
      checkDut("rst_cnt3", 64'h0, 1'b0, 1'b0);
      applyStimulus(8'h61, 1'b0, 64'h0, 1'b0, 64'h0);
      checkDut("rst_thr1", 64'h0, 1'b0, 1'b0);
      applyStimulus(8'hC0, 1'b0, 64'h0, 1'b0, 64'h0);
      checkDut("rst_inh", 64'h0, 1'b0, 1'b0);
      tick();

      $display("[TB] random traffic against model");
      for (int n = 0; n < 600; n++) begin
         rk = $urandom_range(0, 7);
         ra = {3'(rk), 2'b00, 3'($urandom_range(0, 7))};
         case (rk)
            0: rd = ($urandom_range(0, 1) == 1) ? (64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 6)))
                                               : 64'($urandom_range(0, 50));
            2: rd = 64'($urandom_range(0, 63));
            3: rd = 64'($urandom_range(0, 60));
            5: rd = 64'($urandom_range(0, 63));
            6: rd = ($urandom_range(0, 1) == 1) ? 64'h0 : 64'($urandom_range(0, 63));
            default: rd = {32'($urandom), 32'($urandom)};
         endcase
         applyStimulus(ra, $urandom_range(0, 3) == 0, rd, $urandom_range(0, 15) == 0,
                       {32'($urandom), 32'($urandom)});
         modelRead(addr, er, ee);
         ei = modelIrq();
         checkDut($sformatf("rand%0d", n), er, ee, ei);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
